// File: rtl/iccm_port_arbiter.sv
// iccm_port_arbiter
// Single-port arbiter and boot sequencer for the instruction memory.
// Programmer writes always win; core fetch is only served in RUN, after a
// programming session has finished and the read path has drained. The
// core is held in reset in every state except RUN.
module iccm_port_arbiter #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [DW-1:0] prog_wdata_i,
    input  logic          prog_done_i,
    input  logic          fetch_req_i,
    input  logic [AW-1:0] fetch_addr_i,
    output logic          fetch_gnt_o,
    output logic [DW-1:0] fetch_rdata_o,
    output logic          fetch_rvalid_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_rvalid_i,
    output logic          core_hold_o,
    output logic          prog_active_o,
    output logic [AW:0]   wr_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROGRAM,
        ST_DRAIN,
        ST_RUN
    } state_e;

    // Count saturates at 2^AW, which needs the extra MSB of wr_count.
    localparam logic [AW:0] WR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] WR_MAX = {1'b1, {AW{1'b0}}};
    // Number of quiet DRAIN cycles required before releasing the core.
    localparam logic [1:0]  DRAIN_CYCLES = 2'd2;

    state_e      state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic        rd_pending_q, rd_pending_d;
    logic [AW:0] wr_count_q, wr_count_d;
    logic        fetch_gnt;

    // Port arbitration: programmer write first, then fetch (RUN only).
    always_comb begin
        fetch_gnt   = (state_q == ST_RUN) && fetch_req_i && !prog_we_i;
        mem_req_o   = prog_we_i || fetch_gnt;
        mem_we_o    = prog_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (prog_we_i) begin
            mem_addr_o  = prog_addr_i;
            mem_wdata_o = prog_wdata_i;
        end else if (fetch_gnt) begin
            mem_addr_o  = fetch_addr_i;
        end
    end

    // Next state, drain counter, read-pending flag and write count.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        rd_pending_d = rd_pending_q;
        wr_count_d   = wr_count_q;

        if (fetch_gnt) begin
            rd_pending_d = 1'b1;
        end else if (mem_rvalid_i) begin
            rd_pending_d = 1'b0;
        end

        // A write from IDLE or RUN opens a new session and counts as one.
        if (prog_we_i) begin
            if (state_q == ST_IDLE || state_q == ST_RUN) begin
                wr_count_d = WR_ONE;
            end else if (wr_count_q != WR_MAX) begin
                wr_count_d = wr_count_q + WR_ONE;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (prog_done_i) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 2'd0;
                end else if (prog_we_i) begin
                    state_d = ST_PROGRAM;
                end
            end
            ST_PROGRAM: begin
                if (prog_done_i) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 2'd0;
                end
            end
            ST_DRAIN: begin
                // A late write restarts the quiet period.
                if (prog_we_i) begin
                    drain_cnt_d = 2'd0;
                end else begin
                    if (drain_cnt_q != DRAIN_CYCLES) begin
                        drain_cnt_d = drain_cnt_q + 2'd1;
                    end
                    if (drain_cnt_d == DRAIN_CYCLES && !rd_pending_q) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // prog_done in RUN is ignored.
                if (prog_we_i) begin
                    state_d = ST_PROGRAM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any session and drops in-flight reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            drain_cnt_q  <= 2'd0;
            rd_pending_q <= 1'b0;
            wr_count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample
            // the pre-edge values, independent of statement order.
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            rd_pending_q <= rd_pending_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // Read return and status outputs.
    always_comb begin
        fetch_gnt_o    = fetch_gnt;
        fetch_rvalid_o = mem_rvalid_i && rd_pending_q;
        fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
        core_hold_o    = (state_q != ST_RUN);
        prog_active_o  = (state_q == ST_PROGRAM);
        wr_count_o     = wr_count_q;
    end

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed testbench for iccm_port_arbiter: a default-size instance with a
// one-cycle-latency memory model, plus an AW=2 instance for saturation.
module tb_iccm_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_wdata = '0;
    logic          prog_done = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;

    // Main instance
    logic          fetch_gnt, fetch_rvalid, mem_req, mem_we, core_hold, prog_active;
    logic [DW-1:0] fetch_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   wr_count;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Small instance (AW = 2)
    logic          s_fetch_gnt, s_fetch_rvalid, s_mem_req, s_mem_we, s_core_hold, s_prog_active;
    logic [DW-1:0] s_fetch_rdata, s_mem_wdata;
    logic [1:0]    s_mem_addr;
    logic [2:0]    s_wr_count;
    logic          s_mem_rvalid = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    iccm_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata),
        .prog_done_i(prog_done),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
        .fetch_gnt_o(fetch_gnt), .fetch_rdata_o(fetch_rdata), .fetch_rvalid_o(fetch_rvalid),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
        .core_hold_o(core_hold), .prog_active_o(prog_active), .wr_count_o(wr_count)
    );

    iccm_port_arbiter #(.AW(2), .DW(DW)) dut_s (
        .clk_i(clk), .rst_ni(rst_ni),
        .prog_we_i(prog_we), .prog_addr_i(prog_addr[1:0]), .prog_wdata_i(prog_wdata),
        .prog_done_i(prog_done),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr[1:0]),
        .fetch_gnt_o(s_fetch_gnt), .fetch_rdata_o(s_fetch_rdata), .fetch_rvalid_o(s_fetch_rvalid),
        .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
        .mem_rdata_i('0), .mem_rvalid_i(s_mem_rvalid),
        .core_hold_o(s_core_hold), .prog_active_o(s_prog_active), .wr_count_o(s_wr_count)
    );

    // Memory macro model: writes land at the edge, reads return one cycle later.
    always @(posedge clk) begin
        if (mem_req && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_req && !mem_we) mem_rdata <= mem[mem_addr];
        mem_rvalid   <= mem_req && !mem_we;
        s_mem_rvalid <= s_mem_req && !s_mem_we;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (core_hold !== 1'b1) begin miscompares++; $display("FAIL reset_hold: got %0b want 1", core_hold); end
        vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            miscompares++; $display("FAIL reset_mem: req=%0b we=%0b addr=%0h wdata=%0h want all 0", mem_req, mem_we, mem_addr, mem_wdata); end
        vectors++; if (fetch_gnt !== 1'b0 || fetch_rvalid !== 1'b0 || fetch_rdata !== '0) begin
            miscompares++; $display("FAIL reset_fetch: gnt=%0b rvalid=%0b rdata=%0h want 0", fetch_gnt, fetch_rvalid, fetch_rdata); end
        vectors++; if (prog_active !== 1'b0 || wr_count !== '0) begin
            miscompares++; $display("FAIL reset_status: active=%0b count=%0d want 0/0", prog_active, wr_count); end
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_program_boot();
        for (int i = 0; i < 4; i++) begin
            prog_we = 1'b1; prog_addr = AW'(i); prog_wdata = 32'hA0 + 32'(i);
            @(negedge clk);
            vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== 32'hA0 + 32'(i)) begin
                miscompares++; $display("FAIL boot_write%0d: req=%0b we=%0b addr=%0h data=%0h want 1/1/%0h/%0h",
                    i, mem_req, mem_we, mem_addr, mem_wdata, i, 32'hA0 + 32'(i)); end
            tick();
        end
        // Cycle N: prog_done
        prog_we = 1'b0; prog_done = 1'b1;
        @(negedge clk);
        vectors++; if (wr_count !== 13'd4) begin miscompares++; $display("FAIL boot_count: got %0d want 4", wr_count); end
        vectors++; if (prog_active !== 1'b1 || core_hold !== 1'b1) begin
            miscompares++; $display("FAIL boot_program: active=%0b hold=%0b want 1/1", prog_active, core_hold); end
        tick();
        prog_done = 1'b0;
        // N+1, N+2: DRAIN
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            vectors++; if (core_hold !== 1'b1 || prog_active !== 1'b0) begin
                miscompares++; $display("FAIL boot_drain%0d: hold=%0b active=%0b want 1/0", c, core_hold, prog_active); end
            tick();
        end
        // N+3: RUN, fetch address 2
        fetch_req = 1'b1; fetch_addr = AW'(2);
        @(negedge clk);
        vectors++; if (core_hold !== 1'b0) begin miscompares++; $display("FAIL boot_release: hold=%0b want 0", core_hold); end
        vectors++; if (fetch_gnt !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(2)) begin
            miscompares++; $display("FAIL boot_grant: gnt=%0b req=%0b we=%0b addr=%0h want 1/1/0/2", fetch_gnt, mem_req, mem_we, mem_addr); end
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        vectors++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hA2) begin
            miscompares++; $display("FAIL boot_rdata: rvalid=%0b rdata=%0h want 1/a2", fetch_rvalid, fetch_rdata); end
        tick();
    endtask

    task automatic test_collision();
        // Cycle K: fetch of address 1 granted in RUN
        fetch_req = 1'b1; fetch_addr = AW'(1);
        @(negedge clk);
        vectors++; if (fetch_gnt !== 1'b1) begin miscompares++; $display("FAIL coll_grant: gnt=%0b want 1", fetch_gnt); end
        tick();
        // K+1: programmer write collides with the returning read
        fetch_addr = AW'(3); prog_we = 1'b1; prog_addr = AW'(8); prog_wdata = 32'hB8;
        @(negedge clk);
        vectors++; if (fetch_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== AW'(8) || mem_wdata !== 32'hB8) begin
            miscompares++; $display("FAIL coll_write: gnt=%0b we=%0b addr=%0h data=%0h want 0/1/8/b8", fetch_gnt, mem_we, mem_addr, mem_wdata); end
        vectors++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hA1) begin
            miscompares++; $display("FAIL coll_rdata: rvalid=%0b rdata=%0h want 1/a1", fetch_rvalid, fetch_rdata); end
        vectors++; if (core_hold !== 1'b0) begin miscompares++; $display("FAIL coll_hold_n1: hold=%0b want 0", core_hold); end
        tick();
        // K+2: now in PROGRAM
        prog_we = 1'b0;
        @(negedge clk);
        vectors++; if (core_hold !== 1'b1 || prog_active !== 1'b1 || wr_count !== 13'd1) begin
            miscompares++; $display("FAIL coll_program: hold=%0b active=%0b count=%0d want 1/1/1", core_hold, prog_active, wr_count); end
        vectors++; if (fetch_gnt !== 1'b0 || fetch_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL coll_after: gnt=%0b rvalid=%0b want 0/0", fetch_gnt, fetch_rvalid); end
        tick();
    endtask

    task automatic test_fetch_blocked();
        // fetch_req stays high throughout PROGRAM
        @(negedge clk);
        vectors++; if (fetch_gnt !== 1'b0 || mem_req !== 1'b0 || mem_addr !== '0) begin
            miscompares++; $display("FAIL blk_idle: gnt=%0b req=%0b addr=%0h want 0/0/0", fetch_gnt, mem_req, mem_addr); end
        tick();
        prog_we = 1'b1; prog_addr = AW'(9); prog_wdata = 32'hB9;
        @(negedge clk);
        vectors++; if (fetch_gnt !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
            miscompares++; $display("FAIL blk_write: gnt=%0b req=%0b we=%0b want 0/1/1", fetch_gnt, mem_req, mem_we); end
        tick();
    endtask

    task automatic test_simultaneous();
        // Cycle M: write and done together
        prog_we = 1'b1; prog_done = 1'b1; prog_addr = AW'(10); prog_wdata = 32'hBA;
        @(negedge clk);
        vectors++; if (mem_we !== 1'b1 || mem_addr !== AW'(10) || fetch_gnt !== 1'b0) begin
            miscompares++; $display("FAIL sim_write: we=%0b addr=%0h gnt=%0b want 1/a/0", mem_we, mem_addr, fetch_gnt); end
        tick();
        // M+1: DRAIN; a late write restarts the drain period
        prog_done = 1'b0; prog_addr = AW'(11); prog_wdata = 32'hBB;
        @(negedge clk);
        vectors++; if (prog_active !== 1'b0 || core_hold !== 1'b1 || wr_count !== 13'd3) begin
            miscompares++; $display("FAIL sim_drain: active=%0b hold=%0b count=%0d want 0/1/3", prog_active, core_hold, wr_count); end
        vectors++; if (mem_we !== 1'b1 || fetch_gnt !== 1'b0) begin
            miscompares++; $display("FAIL sim_drain_write: we=%0b gnt=%0b want 1/0", mem_we, fetch_gnt); end
        tick();
        prog_we = 1'b0; fetch_addr = AW'(10);
        // M+2, M+3: core still held
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            vectors++; if (core_hold !== 1'b1 || fetch_gnt !== 1'b0) begin
                miscompares++; $display("FAIL sim_hold_m%0d: hold=%0b gnt=%0b want 1/0", c, core_hold, fetch_gnt); end
            tick();
        end
        // M+4: RUN, first grant
        @(negedge clk);
        vectors++; if (core_hold !== 1'b0 || fetch_gnt !== 1'b1 || mem_addr !== AW'(10)) begin
            miscompares++; $display("FAIL sim_run: hold=%0b gnt=%0b addr=%0h want 0/1/a", core_hold, fetch_gnt, mem_addr); end
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        vectors++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hBA) begin
            miscompares++; $display("FAIL sim_rdata: rvalid=%0b rdata=%0h want 1/ba", fetch_rvalid, fetch_rdata); end
        tick();
    endtask

    task automatic test_saturation_reset();
        for (int i = 0; i < 6; i++) begin
            prog_we = 1'b1; prog_addr = AW'(i); prog_wdata = 32'hC0 + 32'(i);
            tick();
        end
        prog_we = 1'b0;
        @(negedge clk);
        vectors++; if (s_wr_count !== 3'd4) begin miscompares++; $display("FAIL sat_count_aw2: got %0d want 4", s_wr_count); end
        vectors++; if (wr_count !== 13'd6) begin miscompares++; $display("FAIL sat_count_aw12: got %0d want 6", wr_count); end
        vectors++; if (s_prog_active !== 1'b1) begin miscompares++; $display("FAIL sat_active: got %0b want 1", s_prog_active); end
        tick();
        // Reset mid-session
        rst_ni = 1'b0;
        #1;
        vectors++; if (core_hold !== 1'b1 || s_core_hold !== 1'b1 || prog_active !== 1'b0 || s_prog_active !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_state: hold=%0b/%0b active=%0b/%0b want 1/1 0/0", core_hold, s_core_hold, prog_active, s_prog_active); end
        vectors++; if (wr_count !== '0 || s_wr_count !== '0 || mem_req !== 1'b0 || fetch_gnt !== 1'b0 || fetch_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_out: count=%0d/%0d req=%0b gnt=%0b rvalid=%0b want 0", wr_count, s_wr_count, mem_req, fetch_gnt, fetch_rvalid); end
        tick();
        rst_ni = 1'b1;
        // Boot the resident image with prog_done alone
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            vectors++; if (core_hold !== 1'b1 || s_core_hold !== 1'b1) begin
                miscompares++; $display("FAIL rst_boot_drain%0d: hold=%0b/%0b want 1/1", c, core_hold, s_core_hold); end
            tick();
        end
        @(negedge clk);
        vectors++; if (core_hold !== 1'b0 || s_core_hold !== 1'b0) begin
            miscompares++; $display("FAIL rst_boot_run: hold=%0b/%0b want 0/0", core_hold, s_core_hold); end
        // Grant a fetch, then reset while its data is returning
        fetch_req = 1'b1; fetch_addr = AW'(9);
        @(negedge clk);
        vectors++; if (fetch_gnt !== 1'b1) begin miscompares++; $display("FAIL rst_fetch_grant: gnt=%0b want 1", fetch_gnt); end
        tick();
        fetch_req = 1'b0;
        rst_ni = 1'b0;
        #1;
        vectors++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== '0) begin
            miscompares++; $display("FAIL rst_discard: rvalid=%0b rdata=%0h want 0/0", fetch_rvalid, fetch_rdata); end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_program_boot();
        test_collision();
        test_fetch_blocked();
        test_simultaneous();
        test_saturation_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
